// File: rtl/issue_buffer_pkg.sv
// Shared issue-stage types: RS/FU packet layouts, function enums, lane state and lane count.
// The ALU and MULT function decode helpers live here too.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 2
`endif

package issue_buffer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PR_W  = 6;
    localparam int unsigned AR_W  = 5;
    localparam int unsigned ROB_W = 5;

    typedef enum logic [1:0] {FU_ALU, FU_MULT, FU_LS, FU_BR} fu_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
        ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_func_t;

    typedef enum logic [1:0] {MULT_MUL, MULT_MULH, MULT_MULHSU, MULT_MULHU} mult_func_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} lane_state_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [1:0]        opa_select;
        logic [2:0]        opb_select;
        logic [AR_W-1:0]   ar_idx;
        logic [PR_W-1:0]   pr_idx;
        logic [PR_W-1:0]   reg1_pr_idx;
        logic [PR_W-1:0]   reg2_pr_idx;
        logic [ROB_W-1:0]  rob_idx;
        fu_sel_t           fu_sel;
        logic [3:0]        op_sel;
        logic              rd_mem;
        logic              wr_mem;
        logic              cond_branch;
        logic              uncond_branch;
        logic              halt;
        logic              illegal;
        logic              csr_op;
    } rs_issue_packet_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   npc;
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [XLEN-1:0]   rs1_value;
        logic [XLEN-1:0]   rs2_value;
        logic [1:0]        opa_select;
        logic [2:0]        opb_select;
        logic [AR_W-1:0]   ar_idx;
        logic [PR_W-1:0]   pr_idx;
        logic [ROB_W-1:0]  rob_idx;
        fu_sel_t           fu_select;
        alu_func_t         alu_func;
        mult_func_t        mult_func;
        logic              rd_mem;
        logic              wr_mem;
        logic              cond_branch;
        logic              uncond_branch;
        logic              halt;
        logic              illegal;
        logic              csr_op;
    } issue_fu_packet_t;

    // Non-ALU units and unused encodings fall back to ADD (address/target arithmetic).
    function automatic alu_func_t decode_alu(input fu_sel_t fu_sel, input logic [3:0] op_sel);
        if (fu_sel == FU_ALU && op_sel <= 4'd9) begin
            return alu_func_t'(op_sel);
        end
        return ALU_ADD;
    endfunction

    function automatic mult_func_t decode_mult(input fu_sel_t fu_sel, input logic [1:0] op_sel);
        return (fu_sel == FU_MULT) ? mult_func_t'(op_sel) : MULT_MUL;
    endfunction

endpackage

// File: rtl/issue_skid_buf.sv
// One issue lane: a 2-entry FIFO (head + skid) with an EMPTY/ONE/TWO state machine.
// head_packet is forced to zero while the lane is empty.
module issue_skid_buf
    import issue_buffer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             push_valid,
    input  issue_fu_packet_t push_packet,
    output logic             push_ready,
    output logic             head_valid,
    output issue_fu_packet_t head_packet,
    input  logic             head_ready
);

    lane_state_t      state_q, state_d;
    issue_fu_packet_t head_q, skid_q;
    logic             accept, consume;
    logic             load_head, load_skid, head_from_skid;

    assign accept  = push_valid & push_ready;
    assign consume = head_valid & head_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d   = StOne;
                    load_head = 1'b1;
                end
            end
            StOne: begin
                if (accept && consume) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = StTwo;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (consume) begin
                    state_d        = StOne;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (squash) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        push_ready  = (state_q != StTwo);
        head_valid  = (state_q != StEmpty);
        head_packet = head_valid ? head_q : '0;
    end

    always_ff @(posedge clock) begin
        if (load_head) begin
            head_q <= push_packet;
        end else if (head_from_skid) begin
            head_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= push_packet;
        end
    end

endmodule

// File: rtl/issue_buffer.sv
// Issue buffer: WAYS independent lanes turning RS packets into operand-resolved FU packets.
// Optional ISSUE_CDB_BYPASS_EN: operands matching a same-cycle CDB broadcast take its value.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter  int unsigned WAYS      = `SUPERSCALAR_WAYS,
    parameter  int unsigned PRF_SIZE  = 64,
    parameter  int unsigned CDB_WAYS  = `SUPERSCALAR_WAYS,
    localparam int unsigned PRF_IDX_W = $clog2(PRF_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic [WAYS-1:0]      rs_valid,
    input  rs_issue_packet_t     rs_packet   [WAYS],
    output logic [WAYS-1:0]      rs_ready,
    output logic [PRF_IDX_W-1:0] prf_rd_idx  [2*WAYS],
    input  logic [31:0]          prf_rd_data [2*WAYS],
    input  logic [CDB_WAYS-1:0]  cdb_valid,
    input  logic [PRF_IDX_W-1:0] cdb_pr_idx  [CDB_WAYS],
    input  logic [31:0]          cdb_value   [CDB_WAYS],
    output logic [WAYS-1:0]      fu_valid,
    output issue_fu_packet_t     fu_packet   [WAYS],
    input  logic [WAYS-1:0]      fu_ready
);

    logic [31:0]      opnd [2*WAYS];
    issue_fu_packet_t fu_in [WAYS];
    logic [WAYS-1:0]  push_valid;

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            prf_rd_idx[2*k]   = PRF_IDX_W'(rs_packet[k].reg1_pr_idx);
            prf_rd_idx[2*k+1] = PRF_IDX_W'(rs_packet[k].reg2_pr_idx);
        end
    end

    always_comb begin
        logic [PR_W-1:0] src;
        logic [31:0]     val;
`ifdef ISSUE_CDB_BYPASS_EN
        logic            hit;
        hit = 1'b0;
`endif
        src = '0;
        val = '0;
        for (int k = 0; k < WAYS; k++) begin
            for (int j = 0; j < 2; j++) begin
                src = (j == 0) ? rs_packet[k].reg1_pr_idx : rs_packet[k].reg2_pr_idx;
                val = prf_rd_data[2*k+j];
`ifdef ISSUE_CDB_BYPASS_EN
                hit = 1'b0;
                // Scan upward and stop at the first hit so the lowest CDB lane wins.
                for (int c = 0; c < CDB_WAYS; c++) begin
                    if (!hit && cdb_valid[c] && cdb_pr_idx[c] == PRF_IDX_W'(src)) begin
                        val = cdb_value[c];
                        hit = 1'b1;
                    end
                end
`endif
                if (src == '0) begin
                    val = '0;
                end
                opnd[2*k+j] = val;
            end
        end
    end

`ifndef ISSUE_CDB_BYPASS_EN
    logic unused_cdb;
    always_comb begin
        unused_cdb = ^cdb_valid;
        for (int c = 0; c < CDB_WAYS; c++) begin
            unused_cdb = unused_cdb ^ (^cdb_pr_idx[c]) ^ (^cdb_value[c]);
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            push_valid[k]           = rs_valid[k] & rs_packet[k].valid;
            fu_in[k]                = '0;
            fu_in[k].valid          = 1'b1;
            fu_in[k].npc            = rs_packet[k].npc;
            fu_in[k].pc             = rs_packet[k].pc;
            fu_in[k].inst           = rs_packet[k].inst;
            fu_in[k].rs1_value      = opnd[2*k];
            fu_in[k].rs2_value      = opnd[2*k+1];
            fu_in[k].opa_select     = rs_packet[k].opa_select;
            fu_in[k].opb_select     = rs_packet[k].opb_select;
            fu_in[k].ar_idx         = rs_packet[k].ar_idx;
            fu_in[k].pr_idx         = rs_packet[k].pr_idx;
            fu_in[k].rob_idx        = rs_packet[k].rob_idx;
            fu_in[k].fu_select      = rs_packet[k].fu_sel;
            fu_in[k].alu_func       = decode_alu(rs_packet[k].fu_sel, rs_packet[k].op_sel);
            fu_in[k].mult_func      = decode_mult(rs_packet[k].fu_sel, rs_packet[k].op_sel[1:0]);
            fu_in[k].rd_mem         = rs_packet[k].rd_mem;
            fu_in[k].wr_mem         = rs_packet[k].wr_mem;
            fu_in[k].cond_branch    = rs_packet[k].cond_branch;
            fu_in[k].uncond_branch  = rs_packet[k].uncond_branch;
            fu_in[k].halt           = rs_packet[k].halt;
            fu_in[k].illegal        = rs_packet[k].illegal;
            fu_in[k].csr_op         = rs_packet[k].csr_op;
        end
    end

    for (genvar k = 0; k < WAYS; k++) begin : g_lane
        issue_skid_buf u_lane (
            .clock       (clock),
            .reset       (reset),
            .squash      (squash),
            .push_valid  (push_valid[k]),
            .push_packet (fu_in[k]),
            .push_ready  (rs_ready[k]),
            .head_valid  (fu_valid[k]),
            .head_packet (fu_packet[k]),
            .head_ready  (fu_ready[k])
        );
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Scoreboard bench for issue_buffer: stimulus queues hand-computed FU packets per lane,
// a negedge monitor pops and compares them whenever a lane's head is consumed.
module tb_issue_buffer;
    import issue_buffer_pkg::*;

    localparam int unsigned WAYS = 2;
    localparam int unsigned CDBW = 2;
    localparam int unsigned PW   = 6;

    logic             clock = 1'b0;
    logic             reset, squash;
    logic [WAYS-1:0]  rs_valid, rs_ready, fu_valid, fu_ready;
    rs_issue_packet_t rs_packet [WAYS];
    logic [PW-1:0]    prf_rd_idx [2*WAYS];
    logic [31:0]      prf_rd_data [2*WAYS];
    logic [CDBW-1:0]  cdb_valid;
    logic [PW-1:0]    cdb_pr_idx [CDBW];
    logic [31:0]      cdb_value [CDBW];
    issue_fu_packet_t fu_packet [WAYS];

    logic [31:0]      prf [64];
    issue_fu_packet_t exp_q [WAYS][$];
    int               total, bad;
    logic             mon_en;

    issue_buffer #(.WAYS(WAYS), .PRF_SIZE(64), .CDB_WAYS(CDBW)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .rs_valid    (rs_valid),
        .rs_packet   (rs_packet),
        .rs_ready    (rs_ready),
        .prf_rd_idx  (prf_rd_idx),
        .prf_rd_data (prf_rd_data),
        .cdb_valid   (cdb_valid),
        .cdb_pr_idx  (cdb_pr_idx),
        .cdb_value   (cdb_value),
        .fu_valid    (fu_valid),
        .fu_packet   (fu_packet),
        .fu_ready    (fu_ready)
    );

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < 2*WAYS; i++) prf_rd_data[i] = prf[prf_rd_idx[i]];
    end

    function automatic rs_issue_packet_t mk_rs(input fu_sel_t fu, input logic [3:0] op,
                                               input logic [5:0] r1, input logic [5:0] r2,
                                               input logic [5:0] pr, input logic [4:0] rob,
                                               input logic [31:0] pc);
        rs_issue_packet_t p = '0;
        p.valid       = 1'b1;
        p.pc          = pc;
        p.npc         = pc + 32'd4;
        p.inst        = {pc[15:0], 16'h0033};
        p.opa_select  = {1'b0, rob[0]};
        p.opb_select  = {1'b0, pr[1:0]};
        p.ar_idx      = rob + 5'd1;
        p.pr_idx      = pr;
        p.reg1_pr_idx = r1;
        p.reg2_pr_idx = r2;
        p.rob_idx     = rob;
        p.fu_sel      = fu;
        p.op_sel      = op;
        p.rd_mem      = (fu == FU_LS);
        p.cond_branch = (fu == FU_BR);
        return p;
    endfunction

    function automatic issue_fu_packet_t mk_exp(input rs_issue_packet_t p, input logic [31:0] v1,
                                                input logic [31:0] v2, input alu_func_t a,
                                                input mult_func_t m);
        issue_fu_packet_t e = '0;
        e.valid = 1'b1;  e.npc = p.npc;  e.pc = p.pc;  e.inst = p.inst;
        e.rs1_value = v1;  e.rs2_value = v2;
        e.opa_select = p.opa_select;  e.opb_select = p.opb_select;
        e.ar_idx = p.ar_idx;  e.pr_idx = p.pr_idx;  e.rob_idx = p.rob_idx;
        e.fu_select = p.fu_sel;  e.alu_func = a;  e.mult_func = m;
        e.rd_mem = p.rd_mem;  e.wr_mem = p.wr_mem;  e.cond_branch = p.cond_branch;
        e.uncond_branch = p.uncond_branch;  e.halt = p.halt;  e.illegal = p.illegal;
        e.csr_op = p.csr_op;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: a head is consumed at the next posedge iff fu_valid & fu_ready at this negedge.
    always @(negedge clock) begin
        issue_fu_packet_t e;
        if (mon_en) begin
            for (int k = 0; k < WAYS; k++) begin
                if (fu_valid[k] && fu_ready[k]) begin
                    total++;
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out lane%0d: got pr=%0d with no packet expected",
                                 k, fu_packet[k].pr_idx);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (fu_packet[k] !== e) begin
                            bad++;
                            $display({"FAIL pkt lane%0d: got rs1=%0h rs2=%0h alu=%0d mult=%0d pr=%0d ",
                                      "rob=%0d pkt=%h expected rs1=%0h rs2=%0h alu=%0d mult=%0d ",
                                      "pr=%0d rob=%0d pkt=%h"}, k,
                                     fu_packet[k].rs1_value, fu_packet[k].rs2_value,
                                     fu_packet[k].alu_func, fu_packet[k].mult_func,
                                     fu_packet[k].pr_idx, fu_packet[k].rob_idx, fu_packet[k],
                                     e.rs1_value, e.rs2_value, e.alu_func, e.mult_func,
                                     e.pr_idx, e.rob_idx, e);
                        end
                    end
                end else if (!fu_valid[k]) begin
                    total++;
                    if (fu_packet[k] !== '0) begin
                        bad++;
                        $display("FAIL idle_zero lane%0d: got pkt=%h expected all-zero",
                                 k, fu_packet[k]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rs_issue_packet_t p0, p1;
        logic [31:0] byp_exp;
        total = 0;  bad = 0;  mon_en = 1'b0;
        reset = 1'b1;  squash = 1'b0;  rs_valid = '0;  fu_ready = '0;  cdb_valid = '0;
        for (int i = 0; i < CDBW; i++) begin cdb_pr_idx[i] = '0; cdb_value[i] = '0; end
        for (int i = 0; i < WAYS; i++) rs_packet[i] = '0;
        for (int i = 0; i < 64; i++) prf[i] = 32'h100 + i;
        prf[0] = 32'd0;  prf[1] = 32'd7;  prf[2] = 32'd8;  prf[5] = 32'd0;

        // Reset state
        step();  step();
        reset = 1'b0;
        check("reset_rs_ready", 64'(rs_ready), 64'd3);
        check("reset_fu_valid", 64'(fu_valid), 64'd0);
        check("reset_pkt0_zero", 64'(fu_packet[0] == '0), 64'd1);
        mon_en = 1'b1;

        // Single ADD on lane 0, one-cycle latency
        fu_ready = 2'b11;
        p0 = mk_rs(FU_ALU, 4'd0, 6'd2, 6'd1, 6'd3, 5'd2, 32'h1000);
        rs_packet[0] = p0;  rs_valid = 2'b01;
        exp_q[0].push_back(mk_exp(p0, 32'd8, 32'd7, ALU_ADD, MULT_MUL));
        step();
        rs_valid = '0;
        check("add_fu_valid", 64'(fu_valid[0]), 64'd1);
        check("add_rs1", 64'(fu_packet[0].rs1_value), 64'd8);
        step();
        check("add_drained", 64'(fu_valid), 64'd0);

        // Back-to-back A, B, C with FU stalled: C must be dropped
        fu_ready = 2'b00;
        p0 = mk_rs(FU_ALU, 4'd1, 6'd1, 6'd2, 6'd10, 5'd4, 32'h2000);
        rs_packet[0] = p0;  rs_valid = 2'b01;
        exp_q[0].push_back(mk_exp(p0, 32'd7, 32'd8, ALU_SUB, MULT_MUL));
        step();
        check("fill_ready_after_a", 64'(rs_ready[0]), 64'd1);
        p0 = mk_rs(FU_MULT, 4'd3, 6'd2, 6'd2, 6'd11, 5'd5, 32'h2004);
        rs_packet[0] = p0;
        exp_q[0].push_back(mk_exp(p0, 32'd8, 32'd8, ALU_ADD, MULT_MULHU));
        step();
        check("fill_ready_after_b", 64'(rs_ready[0]), 64'd0);
        rs_packet[0] = mk_rs(FU_ALU, 4'd4, 6'd1, 6'd1, 6'd12, 5'd6, 32'h2008);
        step();
        check("c_ignored_ready", 64'(rs_ready[0]), 64'd0);
        check("c_ignored_head", 64'(fu_packet[0].pr_idx), 64'd10);
        rs_valid = '0;  fu_ready = 2'b01;
        step();  step();
        check("drain_empty_valid", 64'(fu_valid[0]), 64'd0);
        check("drain_empty_ready", 64'(rs_ready[0]), 64'd1);
        check("drain_queue", 64'(exp_q[0].size()), 64'd0);

        // CDB broadcast on the accept cycle, duplicate tags on both CDB lanes
        fu_ready = 2'b11;
`ifdef ISSUE_CDB_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h0;
`endif
        p1 = mk_rs(FU_ALU, 4'd6, 6'd5, 6'd2, 6'd20, 5'd7, 32'h3000);
        rs_packet[1] = p1;  rs_valid = 2'b10;
        cdb_valid = 2'b11;
        cdb_pr_idx[0] = 6'd5;  cdb_value[0] = 32'h55;
        cdb_pr_idx[1] = 6'd5;  cdb_value[1] = 32'h66;
        exp_q[1].push_back(mk_exp(p1, byp_exp, 32'd8, ALU_XOR, MULT_MUL));
        step();
        rs_valid = '0;  cdb_valid = '0;
        check("cdb_fu_valid", 64'(fu_valid[1]), 64'd1);
        step();

        // pr 0 reads as zero regardless of PRF contents or CDB
        prf[0] = 32'hFF;
        p0 = mk_rs(FU_ALU, 4'd5, 6'd1, 6'd0, 6'd21, 5'd8, 32'h4000);
        p1 = mk_rs(FU_BR, 4'd0, 6'd0, 6'd2, 6'd22, 5'd9, 32'h4100);
        rs_packet[0] = p0;  rs_packet[1] = p1;  rs_valid = 2'b11;
        cdb_valid = 2'b01;  cdb_pr_idx[0] = 6'd0;  cdb_value[0] = 32'h11;
        exp_q[0].push_back(mk_exp(p0, 32'd7, 32'd0, ALU_OR, MULT_MUL));
        exp_q[1].push_back(mk_exp(p1, 32'd0, 32'd8, ALU_ADD, MULT_MUL));
        step();
        rs_valid = '0;  cdb_valid = '0;
        check("zero_both_valid", 64'(fu_valid), 64'd3);
        step();

        // Squash with lane 1 in TWO, lane 0 in ONE, new requests on both
        fu_ready = 2'b00;
        rs_packet[0] = mk_rs(FU_ALU, 4'd0, 6'd1, 6'd2, 6'd40, 5'd12, 32'h6000);
        rs_packet[1] = mk_rs(FU_ALU, 4'd0, 6'd1, 6'd2, 6'd41, 5'd13, 32'h6100);
        rs_valid = 2'b11;
        step();
        rs_packet[1] = mk_rs(FU_ALU, 4'd2, 6'd2, 6'd1, 6'd42, 5'd14, 32'h6104);
        rs_valid = 2'b10;
        step();
        check("presquash_ready", 64'(rs_ready), 64'd1);
        squash = 1'b1;  rs_valid = 2'b11;
        rs_packet[0] = mk_rs(FU_ALU, 4'd0, 6'd1, 6'd1, 6'd43, 5'd15, 32'h6200);
        step();
        squash = 1'b0;  rs_valid = '0;
        check("squash_fu_valid", 64'(fu_valid), 64'd0);
        check("squash_rs_ready", 64'(rs_ready), 64'd3);

        // Reset with both lanes in TWO and simultaneous accept requests
        rs_packet[0] = mk_rs(FU_ALU, 4'd0, 6'd1, 6'd2, 6'd44, 5'd16, 32'h7000);
        rs_packet[1] = mk_rs(FU_ALU, 4'd0, 6'd1, 6'd2, 6'd45, 5'd17, 32'h7100);
        rs_valid = 2'b11;
        step();  step();
        check("prereset_ready", 64'(rs_ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;  rs_valid = '0;
        check("midreset_fu_valid", 64'(fu_valid), 64'd0);
        check("midreset_pkt0_zero", 64'(fu_packet[0] == '0), 64'd1);
        check("midreset_pkt1_zero", 64'(fu_packet[1] == '0), 64'd1);
        check("midreset_rs_ready", 64'(rs_ready), 64'd3);

        // ONE + accept + consume: new packet replaces the consumed head
        fu_ready = 2'b01;
        p0 = mk_rs(FU_ALU, 4'd7, 6'd2, 6'd1, 6'd30, 5'd10, 32'h5000);
        rs_packet[0] = p0;  rs_valid = 2'b01;
        exp_q[0].push_back(mk_exp(p0, 32'd8, 32'd7, ALU_SLL, MULT_MUL));
        step();
        p0 = mk_rs(FU_MULT, 4'd1, 6'd1, 6'd1, 6'd31, 5'd11, 32'h5004);
        rs_packet[0] = p0;
        exp_q[0].push_back(mk_exp(p0, 32'd7, 32'd7, ALU_ADD, MULT_MULH));
        step();
        rs_valid = '0;
        check("swap_valid", 64'(fu_valid[0]), 64'd1);
        check("swap_head_pr", 64'(fu_packet[0].pr_idx), 64'd31);
        step();
        check("swap_drained", 64'(fu_valid[0]), 64'd0);

        check("final_queue0", 64'(exp_q[0].size()), 64'd0);
        check("final_queue1", 64'(exp_q[1].size()), 64'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
